stream_merge_buffer: RTL and testbench

Parametrised packet/metadata merge stage placed after the stream parser. Buffers the 134b-style packet beat stream in a packet FIFO and the parser's per-packet metadata in a meta FIFO. For each packet it re-emits the packet with the leading header bytes overwritten from metadata, or discards it if the metadata requests a drop. Adds admission control, downstream backpressure and statistics counters.

---
 rtl/stream_merge_buffer_if.sv | 31 +++
 rtl/stream_merge_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_stream_merge_buffer.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_merge_buffer_if.sv
// Stream/metadata bus for stream_merge_buffer: beat input, metadata input,
// backpressured beat output and statistics.
interface stream_merge_buffer_if #(
  parameter int DATA_W = 128,
  parameter int META_W = 128
);
  localparam int VLD_W  = $clog2(DATA_W/8);
  localparam int BEAT_W = DATA_W + 2 + VLD_W;

  logic              i_data_valid;
  logic [BEAT_W-1:0] i_data;
  logic              i_meta_valid;
  logic [META_W-1:0] i_meta;
  logic              o_data_valid;
  logic [BEAT_W-1:0] o_data;
  logic              i_out_ready;
  logic [31:0]       o_cnt_pkt_out;
  logic [31:0]       o_cnt_drop_adm;
  logic [31:0]       o_cnt_drop_meta;
  logic              o_err_sync;

  modport slave (
    input  i_data_valid, i_data, i_meta_valid, i_meta, i_out_ready,
    output o_data_valid, o_data, o_cnt_pkt_out, o_cnt_drop_adm, o_cnt_drop_meta, o_err_sync
  );

  modport master (
    output i_data_valid, i_data, i_meta_valid, i_meta, i_out_ready,
    input  o_data_valid, o_data, o_cnt_pkt_out, o_cnt_drop_adm, o_cnt_drop_meta, o_err_sync
  );
endinterface

// File: rtl/stream_merge_buffer.sv
// Packet/metadata merge stage: buffers beats and per-packet metadata, then
// re-emits each packet with its head bytes overwritten, or flushes it.
module stream_merge_buffer #(
  parameter int DATA_W         = 128,
  parameter int PKT_DEPTH_LOG  = 9,
  parameter int META_W         = 128,
  parameter int META_DEPTH_LOG = 4,
  parameter int REPLACE_BYTES  = 12,
  parameter int MAX_BEATS      = 96
) (
  input logic i_clk,
  input logic i_rst,
  stream_merge_buffer_if.slave bus
);
  localparam int VLD_W      = $clog2(DATA_W/8);
  localparam int BEAT_W     = DATA_W + 2 + VLD_W;
  localparam int PKT_DEPTH  = 1 << PKT_DEPTH_LOG;
  localparam int META_DEPTH = 1 << META_DEPTH_LOG;
  localparam int REP_W      = 8*REPLACE_BYTES;
  localparam int PW         = PKT_DEPTH_LOG + 1;
  localparam int MW         = META_DEPTH_LOG + 1;

  typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

  // storage
  logic [BEAT_W-1:0] pkt_mem  [PKT_DEPTH];
  logic              tag_mem  [META_DEPTH];
  logic [META_W-1:0] meta_mem [META_DEPTH];

  logic [PW-1:0] pkt_wr_ptr, pkt_rd_ptr, pkt_cnt, pkt_occ_eff;
  logic [MW-1:0] tag_wr_ptr, tag_rd_ptr, tag_cnt, tag_occ_eff;
  logic [MW-1:0] meta_wr_ptr, meta_rd_ptr, meta_cnt;

  logic pkt_push, pkt_pop, tag_push, tag_pop, tag_din, meta_push, meta_pop;
  logic in_pkt, in_pkt_nxt, keep, keep_nxt;
  logic in_head, in_tail, pkt_room, tag_full, meta_full;
  logic adm_drop, in_err, meta_err, rep_load, out_vld, pkt_done, flush_done;
  logic tag_head, rd_tail;
  logic [BEAT_W-1:0] rd_beat, beat_out;
  logic [META_W-1:0] meta_head;
  logic [REP_W-1:0]  rep_q;
  logic [31:0] cnt_pkt_q, cnt_adm_q, cnt_meta_q;
  logic err_q;
  logic unused_meta;
  state_t state, state_nxt;

  assign pkt_cnt  = pkt_wr_ptr - pkt_rd_ptr;
  assign tag_cnt  = tag_wr_ptr - tag_rd_ptr;
  assign meta_cnt = meta_wr_ptr - meta_rd_ptr;

  assign in_head = bus.i_data[BEAT_W-2];
  assign in_tail = bus.i_data[BEAT_W-1];

  // Admission counts a pop happening in the same cycle as free space.
  assign pkt_occ_eff = pkt_cnt - PW'(pkt_pop);
  assign pkt_room    = (PW'(PKT_DEPTH) - pkt_occ_eff) >= PW'(MAX_BEATS);
  assign tag_occ_eff = tag_cnt - MW'(tag_pop);
  assign tag_full    = tag_occ_eff == MW'(META_DEPTH);
  assign meta_full   = meta_cnt == MW'(META_DEPTH);

  assign tag_head    = tag_mem[tag_rd_ptr[META_DEPTH_LOG-1:0]];
  assign meta_head   = meta_mem[meta_rd_ptr[META_DEPTH_LOG-1:0]];
  assign rd_beat     = pkt_mem[pkt_rd_ptr[PKT_DEPTH_LOG-1:0]];
  assign rd_tail     = rd_beat[BEAT_W-1];
  assign unused_meta = ^meta_head;

  // Meta intake: a tag is only popped if one was already stored (no bypass).
  assign tag_pop   = bus.i_meta_valid && (tag_cnt != '0);
  assign meta_push = tag_pop && tag_head && !meta_full;
  assign meta_err  = bus.i_meta_valid && ((tag_cnt == '0) || meta_full);

  // Ingress framing and admission decision
  always_comb begin
    pkt_push   = 1'b0;
    tag_push   = 1'b0;
    tag_din    = 1'b0;
    adm_drop   = 1'b0;
    in_err     = 1'b0;
    in_pkt_nxt = in_pkt;
    keep_nxt   = keep;
    if (bus.i_data_valid) begin
      if (in_head) begin
        // A head inside a packet restarts framing on this beat.
        in_err = in_pkt;
        if (tag_full) begin
          adm_drop = 1'b1;
          in_err   = 1'b1;
          keep_nxt = 1'b0;
        end else begin
          tag_push = 1'b1;
          tag_din  = pkt_room;
          keep_nxt = pkt_room;
          pkt_push = pkt_room;
          adm_drop = !pkt_room;
        end
        in_pkt_nxt = !in_tail;
      end else if (!in_pkt) begin
        in_err = 1'b1;
      end else begin
        pkt_push = keep;
        if (in_tail) in_pkt_nxt = 1'b0;
      end
    end
  end

  // Output FSM next state, pops and output valid
  always_comb begin
    state_nxt  = state;
    meta_pop   = 1'b0;
    pkt_pop    = 1'b0;
    rep_load   = 1'b0;
    out_vld    = 1'b0;
    pkt_done   = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE:
        if (meta_cnt != '0 && pkt_cnt != '0) begin
          meta_pop  = 1'b1;
          rep_load  = 1'b1;
          state_nxt = meta_head[META_W-1] ? FLUSH : SEND;
        end
      SEND:
        if (pkt_cnt != '0) begin
          out_vld = 1'b1;
          if (bus.i_out_ready) begin
            pkt_pop = 1'b1;
            if (rd_tail) begin
              pkt_done  = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      FLUSH:
        if (pkt_cnt != '0) begin
          pkt_pop = 1'b1;
          if (rd_tail) begin
            flush_done = 1'b1;
            state_nxt  = IDLE;
          end
        end
      default: state_nxt = IDLE;
    endcase
  end

  // Head beat gets its leading bytes from the latched metadata
  always_comb begin
    beat_out = rd_beat;
    if (rd_beat[BEAT_W-2]) beat_out[DATA_W-1 -: REP_W] = rep_q;
  end

  // FIFO storage writes (contents need no reset; pointers gate visibility)
  always_ff @(posedge i_clk) begin
    if (pkt_push)  pkt_mem[pkt_wr_ptr[PKT_DEPTH_LOG-1:0]]    <= bus.i_data;
    if (tag_push)  tag_mem[tag_wr_ptr[META_DEPTH_LOG-1:0]]   <= tag_din;
    if (meta_push) meta_mem[meta_wr_ptr[META_DEPTH_LOG-1:0]] <= bus.i_meta;
  end

  // Pointers, framing state, FSM state and latched replacement bytes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_wr_ptr  <= '0;
      pkt_rd_ptr  <= '0;
      tag_wr_ptr  <= '0;
      tag_rd_ptr  <= '0;
      meta_wr_ptr <= '0;
      meta_rd_ptr <= '0;
      in_pkt      <= 1'b0;
      keep        <= 1'b0;
      state       <= IDLE;
      rep_q       <= '0;
    end else begin
      if (pkt_push)  pkt_wr_ptr  <= pkt_wr_ptr + 1'b1;
      if (pkt_pop)   pkt_rd_ptr  <= pkt_rd_ptr + 1'b1;
      if (tag_push)  tag_wr_ptr  <= tag_wr_ptr + 1'b1;
      if (tag_pop)   tag_rd_ptr  <= tag_rd_ptr + 1'b1;
      if (meta_push) meta_wr_ptr <= meta_wr_ptr + 1'b1;
      if (meta_pop)  meta_rd_ptr <= meta_rd_ptr + 1'b1;
      in_pkt <= in_pkt_nxt;
      keep   <= keep_nxt;
      state  <= state_nxt;
      if (rep_load) rep_q <= meta_head[REP_W-1:0];
    end
  end

  // Statistics and sticky contract-violation flag
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_pkt_q  <= '0;
      cnt_adm_q  <= '0;
      cnt_meta_q <= '0;
      err_q      <= 1'b0;
    end else begin
      if (pkt_done)   cnt_pkt_q  <= cnt_pkt_q + 1'b1;
      if (adm_drop)   cnt_adm_q  <= cnt_adm_q + 1'b1;
      if (flush_done) cnt_meta_q <= cnt_meta_q + 1'b1;
      err_q <= err_q | in_err | meta_err;
    end
  end

  // Output is taken straight from FIFO storage and the latched meta, so it
  // stays put while stalled; zeroed when not valid.
  assign bus.o_data_valid    = out_vld;
  assign bus.o_data          = out_vld ? beat_out : '0;
  assign bus.o_cnt_pkt_out   = cnt_pkt_q;
  assign bus.o_cnt_drop_adm  = cnt_adm_q;
  assign bus.o_cnt_drop_meta = cnt_meta_q;
  assign bus.o_err_sync      = err_q;
endmodule

// File: tb/tb_stream_merge_buffer.sv
// Self-checking bench for stream_merge_buffer with a packet-level reference model.
module tb_stream_merge_buffer;
  localparam int DATA_W = 128;
  localparam int META_W = 128;
  localparam int BEAT_W = 134;
  localparam int R      = 12;
  localparam int MAXB   = 96;
  localparam int PDEPTH = 512;
  localparam int TDEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  stream_merge_buffer_if #(.DATA_W(DATA_W), .META_W(META_W)) bus ();

  stream_merge_buffer #(
    .DATA_W(DATA_W), .PKT_DEPTH_LOG(9), .META_W(META_W), .META_DEPTH_LOG(4),
    .REPLACE_BYTES(R), .MAX_BEATS(MAXB)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [BEAT_W-1:0] exp_q[$];
  logic [BEAT_W-1:0] pend_q[$];
  int                pend_len[$];
  bit                tag_q[$];
  int  exp_occ = 0;
  int  exp_pkt = 0, exp_adm = 0, exp_dm = 0;
  bit  exp_err = 0, m_in_pkt = 0, m_keep = 0;
  bit  stalled = 0;
  logic [BEAT_W-1:0] prev_data = '0;
  int  cyc = 0;
  int  ready_mode = 0;

  task automatic chk(string tag, logic [BEAT_W-1:0] obs, logic [BEAT_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [BEAT_W-1:0] replace(logic [BEAT_W-1:0] b, logic [8*R-1:0] rep);
    for (int k = 0; k < R; k++) b[DATA_W-1-8*k -: 8] = rep[8*R-1-8*k -: 8];
    return b;
  endfunction

  function automatic void model_reset();
    exp_q.delete(); pend_q.delete(); pend_len.delete(); tag_q.delete();
    exp_occ = 0; exp_pkt = 0; exp_adm = 0; exp_dm = 0;
    exp_err = 0; m_in_pkt = 0; m_keep = 0;
  endfunction

  // One clock: observe the beat transferring at the coming edge, then advance.
  task automatic tick();
    logic [BEAT_W-1:0] e;
    if (!rst) begin
      if (stalled) begin
        chk("hold_valid", BEAT_W'(bus.o_data_valid), BEAT_W'(1));
        chk("hold_data", bus.o_data, prev_data);
      end
      if (bus.o_data_valid && bus.i_out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_beat: observed %h expected no beat", bus.o_data);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("beat", bus.o_data, e);
          exp_occ--;
          if (e[BEAT_W-1]) exp_pkt++;
        end
      end
      stalled   = bus.o_data_valid && !bus.i_out_ready;
      prev_data = bus.o_data;
    end else begin
      stalled = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ready_mode == 1) bus.i_out_ready = ($urandom_range(0, 3) != 0);
    else if (ready_mode == 2) bus.i_out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
  endtask

  task automatic send_beat(logic [1:0] tg, logic [3:0] v, logic [127:0] d);
    logic [BEAT_W-1:0] b;
    int occ;
    b   = {tg, v, d};
    occ = exp_occ - ((bus.o_data_valid && bus.i_out_ready) ? 1 : 0);
    if (tg[0]) begin
      if (m_in_pkt) exp_err = 1;
      if (tag_q.size() == TDEPTH) begin
        exp_err = 1; exp_adm++; m_keep = 0;
      end else begin
        m_keep = (PDEPTH - occ >= MAXB);
        tag_q.push_back(m_keep);
        if (!m_keep) exp_adm++;
      end
      if (m_keep) begin pend_q.push_back(b); pend_len.push_back(1); exp_occ++; end
      m_in_pkt = !tg[1];
    end else if (!m_in_pkt) begin
      exp_err = 1;
    end else begin
      if (m_keep) begin
        pend_q.push_back(b);
        pend_len[pend_len.size()-1] = pend_len[pend_len.size()-1] + 1;
        exp_occ++;
      end
      if (tg[1]) m_in_pkt = 0;
    end
    bus.i_data_valid = 1'b1;
    bus.i_data       = b;
    tick();
    bus.i_data_valid = 1'b0;
  endtask

  task automatic send_pkt(int n, logic [7:0] b0, bit fix_b0);
    for (int i = 0; i < n; i++) begin
      logic [1:0]   tg;
      logic [127:0] d;
      tg = (n == 1) ? 2'b11 : (i == 0) ? 2'b01 : (i == n-1) ? 2'b10 : 2'b00;
      d  = rnd128();
      if (i == 0 && fix_b0) d[127:120] = b0;
      send_beat(tg, 4'($urandom_range(0, 15)), d);
    end
  endtask

  task automatic send_meta(bit drop, logic [8*R-1:0] rep);
    logic [BEAT_W-1:0] b;
    bit t;
    int n;
    if (tag_q.size() == 0) begin
      exp_err = 1;
    end else begin
      t = tag_q.pop_front();
      if (t) begin
        n = pend_len.pop_front();
        for (int i = 0; i < n; i++) begin
          b = pend_q.pop_front();
          if (!drop) exp_q.push_back(i == 0 ? replace(b, rep) : b);
        end
        if (drop) begin exp_dm++; exp_occ -= n; end
      end
    end
    bus.i_meta_valid = 1'b1;
    bus.i_meta       = {drop, 31'($urandom), rep};
    tick();
    bus.i_meta_valid = 1'b0;
  endtask

  task automatic drain(string tag, int budget);
    int i = 0;
    while (exp_q.size() != 0 && i < budget) begin tick(); i++; end
    chk(tag, BEAT_W'(exp_q.size()), '0);
    repeat (4) tick();
  endtask

  task automatic chk_cnts(string tag);
    chk({tag, "_pkt_out"},   BEAT_W'(bus.o_cnt_pkt_out),   BEAT_W'(exp_pkt));
    chk({tag, "_drop_adm"},  BEAT_W'(bus.o_cnt_drop_adm),  BEAT_W'(exp_adm));
    chk({tag, "_drop_meta"}, BEAT_W'(bus.o_cnt_drop_meta), BEAT_W'(exp_dm));
    chk({tag, "_err"},       BEAT_W'(bus.o_err_sync),      BEAT_W'(exp_err));
  endtask

  task automatic chk_idle_zero(string tag);
    chk({tag, "_valid"}, BEAT_W'(bus.o_data_valid), '0);
    chk({tag, "_data"},  bus.o_data, '0);
    chk_cnts(tag);
  endtask

  initial begin
    logic [8*R-1:0] rep;
    bus.i_data_valid = 1'b0;
    bus.i_data       = '0;
    bus.i_meta_valid = 1'b0;
    bus.i_meta       = '0;
    bus.i_out_ready  = 1'b1;

    // reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    model_reset();
    chk_idle_zero("reset");

    // single packet with header replacement and latency check
    for (int k = 0; k < R; k++) rep[8*R-1-8*k -: 8] = 8'(8'h11 + k);
    send_pkt(4, 8'hAA, 1);
    send_meta(0, rep);
    chk("lat_n1_valid", BEAT_W'(bus.o_data_valid), '0);
    tick();
    chk("lat_n2_valid", BEAT_W'(bus.o_data_valid), BEAT_W'(1));
    chk("head_byte0", BEAT_W'(bus.o_data[127:120]), BEAT_W'(8'h11));
    chk("head_rep", BEAT_W'(bus.o_data[127:32]), BEAT_W'(rep));
    drain("drain_single", 50);
    chk_cnts("single");

    // meta drop in the middle of three packets
    for (int p = 0; p < 3; p++) begin
      send_pkt($urandom_range(2, 6), 8'h00, 0);
      send_meta(p == 1, {$urandom, $urandom, $urandom});
    end
    drain("drain_drop", 100);
    chk_cnts("drop");

    // backpressure with ready pattern 1,0,0,1
    send_pkt(8, 8'h00, 0);
    send_meta(0, {$urandom, $urandom, $urandom});
    ready_mode = 2;
    drain("drain_bp", 100);
    ready_mode = 0;
    bus.i_out_ready = 1'b1;
    chk_cnts("bp");

    // randomized packets, drops and backpressure
    ready_mode = 1;
    for (int p = 0; p < 24; p++) begin
      send_pkt($urandom_range(1, 10), 8'h00, 0);
      send_meta($urandom_range(0, 3) == 0, {$urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 3)) tick();
    end
    drain("drain_rand", 600);
    ready_mode = 0;
    bus.i_out_ready = 1'b1;
    repeat (20) tick();
    chk_cnts("rand");

    // admission drop: 422 beats buffered, 90 free < 96
    bus.i_out_ready = 1'b0;
    tick();
    for (int p = 0; p < 4; p++) send_pkt(96, 8'h00, 0);
    send_pkt(38, 8'h00, 0);
    send_pkt(5, 8'h00, 0);
    chk_cnts("adm_fill");
    for (int p = 0; p < 6; p++) send_meta(0, {$urandom, $urandom, $urandom});
    bus.i_out_ready = 1'b1;
    drain("drain_adm", 800);
    send_pkt(3, 8'h00, 0);
    send_meta(0, {$urandom, $urandom, $urandom});
    drain("drain_adm_next", 50);
    chk_cnts("adm");

    // reset during beat 2 of an output packet
    send_pkt(6, 8'h00, 0);
    send_meta(0, {$urandom, $urandom, $urandom});
    for (int i = 0; i < 40 && exp_q.size() > 4; i++) tick();
    chk("rst_mid_reach", BEAT_W'(exp_q.size()), BEAT_W'(4));
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    chk_idle_zero("rst_mid");
    tick();
    chk_idle_zero("rst_mid_idle");
    send_pkt(5, 8'h00, 0);
    send_meta(0, {$urandom, $urandom, $urandom});
    drain("drain_after_rst", 50);
    chk_cnts("after_rst");

    // framing error: body beat outside a packet, sticky until reset
    send_beat(2'b00, 4'h0, rnd128());
    chk_cnts("err_body");
    repeat (5) tick();
    chk("err_body_held", BEAT_W'(bus.o_err_sync), BEAT_W'(1));
    rst = 1'b1;
    model_reset();
    tick();
    rst = 1'b0;
    chk_idle_zero("err_cleared");

    // meta with the tag FIFO empty
    send_meta(0, {$urandom, $urandom, $urandom});
    chk_cnts("err_meta");
    repeat (5) tick();
    chk("err_meta_held", BEAT_W'(bus.o_err_sync), BEAT_W'(1));
    chk("err_meta_novalid", BEAT_W'(bus.o_data_valid), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
